// File: rtl/mem_dump_reader.sv
// mem_dump_reader: walks a range of data-BRAM words through the debug port and
// streams each word as four little-endian bytes followed by one checksum byte
// on a valid/ready byte interface. Holds the core stalled (busy_o) while dumping.

module mem_dump_reader #(
   parameter int unsigned ADDR_WIDTH = 12,
   // Fixed at 32: the serializer emits exactly four bytes per word.
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] base_addr_i,
   input  logic [10:0]           word_count_i,
   output logic [ADDR_WIDTH-1:0] debug_addr_o,
   input  logic [DATA_WIDTH-1:0] debug_data_i,
   output logic [7:0]            tx_data_o,
   output logic                  tx_valid_o,
   input  logic                  tx_ready_i,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int unsigned CountWidth = 11;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StSend,
      StCsum,
      StDone
   } state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [CountWidth-1:0]   remain_q, remain_d;
   logic [7:0]              csum_q, csum_d;
   logic [1:0]              idx_q, idx_d;
   logic [DATA_WIDTH-1:0]   word_q, word_d;

   logic                    tx_hs;
   logic [7:0]              send_byte;

   assign tx_hs        = tx_valid_o & tx_ready_i;
   assign debug_addr_o = addr_q;

   // Byte select for SEND, least significant byte first.
   always_comb begin
      send_byte = word_q[7:0];
      unique case (idx_q)
         2'd0: send_byte = word_q[7:0];
         2'd1: send_byte = word_q[15:8];
         2'd2: send_byte = word_q[23:16];
         2'd3: send_byte = word_q[31:24];
         default: send_byte = word_q[7:0];
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = (word_count_i == '0) ? StCsum : StFetch;
            end
         end
         StFetch: begin
            state_d = StSend;
         end
         StSend: begin
            if (tx_hs && (idx_q == 2'd3)) begin
               state_d = (remain_q == CountWidth'(1)) ? StCsum : StFetch;
            end
         end
         StCsum: begin
            if (tx_hs) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Output decode; everything is a pure function of the current state so the
   // byte and valid stay stable across backpressure.
   always_comb begin
      tx_valid_o = 1'b0;
      tx_data_o  = 8'h00;
      busy_o     = 1'b1;
      done_o     = 1'b0;
      unique case (state_q)
         StIdle: begin
            busy_o = 1'b0;
         end
         StFetch: begin
         end
         StSend: begin
            tx_valid_o = 1'b1;
            tx_data_o  = send_byte;
         end
         StCsum: begin
            tx_valid_o = 1'b1;
            tx_data_o  = csum_q;
         end
         StDone: begin
            done_o = 1'b1;
         end
         default: begin
            busy_o = 1'b0;
         end
      endcase
   end

   // Datapath next-state: address walk, word count, byte index and checksum.
   always_comb begin
      addr_d   = addr_q;
      remain_d = remain_q;
      csum_d   = csum_q;
      idx_d    = idx_q;
      word_d   = word_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               // Word-align the base address.
               addr_d   = base_addr_i & ~ADDR_WIDTH'(3);
               remain_d = word_count_i;
               csum_d   = 8'h00;
               idx_d    = 2'd0;
            end
         end
         StFetch: begin
            word_d = debug_data_i;
            idx_d  = 2'd0;
         end
         StSend: begin
            if (tx_hs) begin
               csum_d = csum_q + send_byte;
               if (idx_q == 2'd3) begin
                  remain_d = remain_q - CountWidth'(1);
                  // Wraps modulo 2^ADDR_WIDTH.
                  addr_d   = addr_q + ADDR_WIDTH'(4);
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
         end
         default: begin
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         addr_q   <= '0;
         remain_q <= '0;
         csum_q   <= '0;
         idx_q    <= '0;
         word_q   <= '0;
      end else begin
         addr_q   <= addr_d;
         remain_q <= remain_d;
         csum_q   <= csum_d;
         idx_q    <= idx_d;
         word_q   <= word_d;
      end
   end

   // A stalled byte must not change or be withdrawn.
   tx_hold_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (tx_valid_o && !tx_ready_i) |=> (tx_valid_o && $stable(tx_data_o)));

   // The BRAM address only moves when a word has been fully sent.
   addr_stable_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (state_q == StSend && !(tx_hs && idx_q == 2'd3)) |=> $stable(debug_addr_o));

endmodule

// File: doc/mem_dump_reader.md
# mem_dump_reader

Read-back engine for the data BRAM debug port. On a start pulse it walks a range of word addresses through `debug_addr`/`debug_data` and streams each word out as four little-endian bytes, then one checksum byte, on a valid/ready byte interface that feeds the board UART transmitter. It sits beside the data BRAM in the rv32i_sc top level. It also holds the core stalled while a dump is in progress, giving hardware the same post-run memory inspection the simulation flow performs through the debug port.

## Interface
- `ADDR_WIDTH`, 12: BRAM byte-address width.
- `DATA_WIDTH`, 32: BRAM word width. Fixed at 32; the byte serializer depends on it.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first byte address. Bits [1:0] are ignored (forced to 0).
- `word_count`  in  11  number of words to dump, 0..1024. Latched on start.
- `debug_addr`  out  ADDR_WIDTH  address driven to the data BRAM debug port.
- `debug_data`  in  DATA_WIDTH  combinational read data for `debug_addr`.
- `tx_data`  out  8  byte to transmit.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  sink accepts the byte on a cycle where `tx_valid` and `tx_ready` are both 1.
- `busy`  out  1  high in every state except IDLE. Wired to the PC stall input.
- `done`  out  1  one-cycle pulse after the checksum byte is accepted.

## Operation
- FSM states: IDLE, FETCH, SEND, CSUM, DONE.
- **IDLE**
  - On `start`=1: latch `base_addr & ~3` into the address register, latch `word_count` into the remaining counter, and clear the checksum and the byte index.
  - Then go to CSUM if `word_count`==0, otherwise to FETCH.
- **FETCH** (exactly 1 cycle)
  - `debug_addr` shows the current address for the whole cycle.
  - At the closing edge, capture `debug_data` into the word register, set byte index to 0, and go to SEND.
- **SEND**
  - `tx_valid`=1 and `tx_data` = word byte[index], LSB first (index 0 = bits 7:0).
  - On handshake: add the byte to the checksum (mod 256).
  - If index<3: increment the index.
  - If index==3: decrement the remaining counter and add 4 to the address (wraps modulo 2^ADDR_WIDTH). Then go to CSUM if remaining was 1, otherwise to FETCH.
- **CSUM**
  - `tx_valid`=1 and `tx_data` = checksum, the 8-bit sum of all data bytes sent in this dump.
  - On handshake, go to DONE.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE.
- **Handshake rules**
  - While `tx_valid`=1 and `tx_ready`=0, `tx_data` and `tx_valid` hold stable.
  - `tx_valid` never drops before its handshake.
- `start` is ignored in any state other than IDLE.
- `debug_addr` always equals the address register. It does not change during SEND.
- A dump always emits 4·N+1 bytes, where N = `word_count`.

## Timing
- **Reset values** (`rst`=0, async): state IDLE, `debug_addr`=0, `tx_data`=0, `tx_valid`=0, `busy`=0, `done`=0, all counters and the checksum 0.
- Cycle numbering: cycle 0 is the cycle in which `start` is sampled. With `tx_ready` held at 1:
  - word k has FETCH in cycle 1+5k and its bytes in cycles 2+5k .. 5+5k;
  - the checksum byte is in cycle 5N+1;
  - `done` is in cycle 5N+2.
- N=0: checksum byte 0x00 in cycle 1, `done` in cycle 2.
- `busy` rises in cycle 1 and falls in the cycle after `done`.
- Each cycle of backpressure adds exactly one cycle of latency.
- Reset asserted mid-dump: immediate abort. No `done` pulse and no further bytes. The next `start` after release runs a full dump normally.

## Test plan
- **Basic dump:** mem[0x0]=0x08, mem[0x4]=0x0A, mem[0x8]=0x0C; base 0x000, count 3, `tx_ready`=1 -> bytes 08 00 00 00 0A 00 00 00 0C 00 00 00 1E, `done` in cycle 17, `busy` high in cycles 1–17.
- **Backpressure:** same setup, `tx_ready` alternating 1/0 and then random -> identical 13-byte sequence with no duplicated or dropped bytes, and `tx_data` stable throughout every stall.
- **Zero count / checksum overflow:**
  - count 0 -> a single byte 0x00, `done` in cycle 2;
  - words 0xFFFFFFFF and 0x01020304 -> checksum 0x06.
- **Address rules:**
  - base 0xFFC, count 2 -> `debug_addr` 0xFFC then 0x000;
  - base 0x006 -> first read at 0x004.
- **Control edge cases:**
  - `start` pulsed during SEND -> ignored, byte count unchanged;
  - `rst`=0 during word 1 -> all outputs 0 at once, no `done`;
  - a fresh `start` after release -> a correct full dump.
